// File: rtl/rs_syndrome_calc_pkg.sv
// rs_syndrome_calc_pkg: GF(2^8) constants, bus types and constant-multiplier helpers
package rs_syndrome_calc_pkg;
    localparam int N_LEN = 255;
    localparam int ROOTS_NUM = 16;
    localparam int SYMB_WIDTH = 8;
    localparam int BUS_WIDTH_IN_SYMB = 4;
    localparam int FIRST_ROOT = 1;
    localparam logic [SYMB_WIDTH:0] POLY = 9'd285;
    localparam int CNT_W = $clog2(N_LEN + 2);
    localparam int K_W = $clog2(BUS_WIDTH_IN_SYMB + 1);

    typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] synd_vec_t;
    typedef logic [BUS_WIDTH_IN_SYMB-1:0][SYMB_WIDTH-1:0] bus_symb_t;
    typedef logic [BUS_WIDTH_IN_SYMB:0][SYMB_WIDTH-1:0] pow_vec_t;

    function automatic logic [SYMB_WIDTH-1:0] gf_mult_const(input logic [SYMB_WIDTH-1:0] c,
                                                            input logic [SYMB_WIDTH-1:0] x);
        logic [SYMB_WIDTH-1:0] p, t;
        p = '0;
        t = x;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            p = c[i] ? p ^ t : p;
            t = t[SYMB_WIDTH-1] ? (t << 1) ^ POLY[SYMB_WIDTH-1:0] : t << 1;
        end
        return p;
    endfunction

    function automatic logic [SYMB_WIDTH-1:0] gen_root_pow_tbl(input int j, input int k);
        logic [SYMB_WIDTH-1:0] p;
        p = SYMB_WIDTH'(1);
        for (int i = 0; i < ((FIRST_ROOT + j) * k) % (2 ** SYMB_WIDTH - 1); i++)
            p = gf_mult_const(p, SYMB_WIDTH'(2));
        return p;
    endfunction

    function automatic pow_vec_t gen_pow_vec(input int j);
        pow_vec_t v;
        for (int k = 0; k <= BUS_WIDTH_IN_SYMB; k++) v[k] = gen_root_pow_tbl(j, k);
        return v;
    endfunction
endpackage

// File: rtl/rs_syndrome_calc_if.sv
// rs_syndrome_calc_if: input symbol stream and syndrome output handshake
interface rs_syndrome_calc_if;
    import rs_syndrome_calc_pkg::*;
    logic s_tvalid, s_tready, s_tlast;
    bus_symb_t s_tdata;
    logic [BUS_WIDTH_IN_SYMB-1:0] s_tkeep;
    logic m_valid, m_ready, m_err_det, m_len_err;
    synd_vec_t m_synd;
    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, m_ready,
        input  s_tready, m_valid, m_synd, m_err_det, m_len_err
    );
    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_ready,
        output s_tready, m_valid, m_synd, m_err_det, m_len_err
    );
endinterface

// File: rtl/rs_syndrome_calc_synd_cell.sv
// rs_synd_cell: one syndrome accumulator updated by Horner's rule over k lanes per beat
module rs_synd_cell
    import rs_syndrome_calc_pkg::*;
#(
    parameter int J = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  bus_symb_t             i_data,
    input  logic [K_W-1:0]        i_k,
    output logic [SYMB_WIDTH-1:0] o_next
);
    localparam pow_vec_t POW = gen_pow_vec(J);
    logic [SYMB_WIDTH-1:0] r_acc, w_next;
    // k = 0 leaves the accumulator untouched, so an empty beat is a no-op
    always_comb begin
        w_next = r_acc;
        for (int k = 1; k <= BUS_WIDTH_IN_SYMB; k++) begin
            if (int'(i_k) == k) begin
                w_next = gf_mult_const(POW[k], r_acc);
                for (int i = 0; i < k; i++) w_next = w_next ^ gf_mult_const(POW[k-1-i], i_data[i]);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst || i_clr) r_acc <= '0;
        else if (i_en) r_acc <= w_next;
    end
    assign o_next = w_next;
endmodule

// File: rtl/rs_syndrome_calc.sv
// rs_syndrome_calc: streaming RS syndrome calculator with a double-buffered result register
module rs_syndrome_calc
    import rs_syndrome_calc_pkg::*;
(
    input logic clk,
    input logic rst,
    rs_syndrome_calc_if.slave bus
);
    logic w_ready, w_acc, w_close;
    logic [K_W-1:0] w_k;
    logic [CNT_W-1:0] r_cnt, w_sum, w_cnt_next;
    logic r_valid, r_err, r_len;
    synd_vec_t r_synd, w_next;

    // only a closing beat needs the result register, so only it can stall
    assign w_ready = !rst && !(bus.s_tlast && r_valid && !bus.m_ready);
    assign w_acc = bus.s_tvalid && w_ready;
    assign w_close = w_acc && bus.s_tlast;
    assign w_k = K_W'($countones(bus.s_tkeep));
    assign w_sum = r_cnt + CNT_W'(w_k);
    assign w_cnt_next = w_sum > CNT_W'(N_LEN + 1) ? CNT_W'(N_LEN + 1) : w_sum;

    for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_cell
        rs_synd_cell #(.J(j)) u_cell (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_acc),
            .i_clr  (w_close),
            .i_data (bus.s_tdata),
            .i_k    (w_k),
            .o_next (w_next[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_synd  <= '0;
            r_err   <= 1'b0;
            r_len   <= 1'b0;
        end else begin
            r_cnt   <= w_close ? '0 : w_acc ? w_cnt_next : r_cnt;
            r_valid <= w_close || (r_valid && !bus.m_ready);
            if (w_close) begin
                r_synd <= w_next;
                r_err  <= |w_next;
                r_len  <= (w_cnt_next != CNT_W'(N_LEN));
            end
        end
    end

    assign bus.s_tready  = w_ready;
    assign bus.m_valid   = r_valid;
    assign bus.m_synd    = r_synd;
    assign bus.m_err_det = r_err;
    assign bus.m_len_err = r_len;
endmodule
